// File: rtl/fft_pkg.sv
// Shared FFT geometry, serializer state type and bin-index bit reversal.
// Pure definitions: no logic, no latency, no flow control.
package fft_pkg;

  localparam int FFT_N     = 8;
  localparam int FFT_LOG2N = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] k);
    logic [FFT_LOG2N-1:0] r;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      r[b] = k[FFT_LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// One frame bank: FFT_N x DATA_W registers, whole-frame write on wr_en_i, indexed read.
// Write lands at the next edge; read is combinational; no flow control of its own.
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                           clk,
  input  logic                           wr_en_i,
  input  logic [FFT_N-1:0][DATA_W-1:0]   wr_frame_i,
  input  logic [FFT_LOG2N-1:0]           rd_addr_i,
  output logic [DATA_W-1:0]              rd_data_o
);

  logic [FFT_N-1:0][DATA_W-1:0] mem_q;

  // Storage is deliberately left unreset; the full flags in the parent decide validity.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q <= wr_frame_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fft_out_serializer.sv
// Ping/pong buffered parallel-to-serial FFT output, 1-cycle accept-to-first-sample, no bubble
// between queued frames; frame_ready is registered. Define FFT_SER_BITREV_EN for natural bin order.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  input  logic [DATA_W-1:0] in8,
  input  logic              frame_valid,
  output logic              frame_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_index,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  localparam logic [FFT_LOG2N-1:0] LAST_IDX = FFT_LOG2N'(FFT_N - 1);

  ser_state_e state_q, state_d;
  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [FFT_LOG2N-1:0] idx_q, idx_d;

  logic accept;
  logic beat;
  logic last_beat;
  logic streaming;

  logic [FFT_N-1:0][DATA_W-1:0] frame_in;
  logic [FFT_LOG2N-1:0]         rd_addr;
  logic [DATA_W-1:0]            ping_dat;
  logic [DATA_W-1:0]            pong_dat;

  assign frame_in = {in8, in7, in6, in5, in4, in3, in2, in1};

`ifdef FFT_SER_BITREV_EN
  assign rd_addr = bitrev(idx_q);
`else
  assign rd_addr = idx_q;
`endif

  fft_frame_buf #(.DATA_W(DATA_W)) u_ping (
    .clk        (clk),
    .wr_en_i    (accept && !wr_sel_q),
    .wr_frame_i (frame_in),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (ping_dat)
  );

  fft_frame_buf #(.DATA_W(DATA_W)) u_pong (
    .clk        (clk),
    .wr_en_i    (accept && wr_sel_q),
    .wr_frame_i (frame_in),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (pong_dat)
  );

  assign streaming   = (state_q == ST_STREAM);
  assign frame_ready = ~(full_q[0] & full_q[1]);
  assign accept      = frame_valid & frame_ready;
  assign beat        = streaming & out_ready;
  assign last_beat   = beat & (idx_q == LAST_IDX);

  // Buffers fill and drain in strict alternation, so wr_sel always names an empty bank
  // whenever frame_ready is high, and accept/release never touch the same bank.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;
    state_d  = state_q;

    if (accept) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end

    if (beat) begin
      idx_d = idx_q + 1'b1;
    end

    if (last_beat) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end

    // Next-state looks at full_d so a frame accepted on the same edge starts without a bubble.
    case (state_q)
      ST_IDLE: begin
        if (full_d[rd_sel_q]) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_beat) begin
          state_d = full_d[~rd_sel_q] ? ST_STREAM : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      idx_q    <= idx_d;
    end
  end

  assign out_valid = streaming;
  assign out_index = idx_q;
  assign out_last  = streaming & (idx_q == LAST_IDX);
  assign out_data  = streaming ? (rd_sel_q ? pong_dat : ping_dat) : '0;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: cycle table for single/stalled frames plus
// hand sequences for back-to-back, full-buffer refusal and mid-frame reset.
module tb_fft_out_serializer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in1, in2, in3, in4, in5, in6, in7, in8;
  logic          frame_valid;
  logic          frame_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_index;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_out_serializer #(.DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
    .in4         (in4),
    .in5         (in5),
    .in6         (in6),
    .in7         (in7),
    .in8         (in8),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready)
  );

  typedef struct packed {
    logic          fv;
    logic [DW-1:0] base;
    logic          ordy;
    logic          efr;
    logic          eov;
    logic [2:0]    eidx;
    logic [DW-1:0] edat;
    logic          elast;
  } vec_t;

  vec_t tbl[$];

  // Input position that supplies output sample k.
  function automatic logic [2:0] pos_of(input logic [2:0] k);
`ifdef FFT_SER_BITREV_EN
    case (k)
      3'd0: return 3'd0;
      3'd1: return 3'd4;
      3'd2: return 3'd2;
      3'd3: return 3'd6;
      3'd4: return 3'd1;
      3'd5: return 3'd5;
      3'd6: return 3'd3;
      default: return 3'd7;
    endcase
`else
    return k;
`endif
  endfunction

  function automatic logic [DW-1:0] smp(input logic [DW-1:0] base, input logic [2:0] k);
    return base + {5'b0, pos_of(k)};
  endfunction

  function automatic vec_t mk(input logic fv, input logic [DW-1:0] base, input logic ordy,
                              input logic efr, input logic eov, input logic [2:0] eidx,
                              input logic [DW-1:0] edat, input logic elast);
    vec_t v;
    v.fv = fv; v.base = base; v.ordy = ordy;
    v.efr = efr; v.eov = eov; v.eidx = eidx; v.edat = edat; v.elast = elast;
    return v;
  endfunction

  task automatic set_frame(input logic [DW-1:0] base);
    in1 = base;         in2 = base + 8'd1; in3 = base + 8'd2; in4 = base + 8'd3;
    in5 = base + 8'd4;  in6 = base + 8'd5; in7 = base + 8'd6; in8 = base + 8'd7;
  endtask

  task automatic check(input string nm, input logic efr, input logic eov, input logic [2:0] eidx,
                       input logic [DW-1:0] edat, input logic elast);
    n_vec++;
    if (frame_ready !== efr || out_valid !== eov || out_index !== eidx ||
        out_data !== edat || out_last !== elast) begin
      n_bad++;
      $display("FAIL %s: got rdy=%0b vld=%0b idx=%0d dat=%h last=%0b, want rdy=%0b vld=%0b idx=%0d dat=%h last=%0b",
               nm, frame_ready, out_valid, out_index, out_data, out_last,
               efr, eov, eidx, edat, elast);
    end
  endtask

  task automatic chk_beat(input string nm, input logic efr, input logic [DW-1:0] base,
                          input logic [2:0] k);
    check(nm, efr, 1'b1, k, smp(base, k), k == 3'd7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int seen;

    rst = 1'b1; frame_valid = 1'b0; out_ready = 1'b0; set_frame(8'h00);

    // Single frame, then a frame with stalls on sample 2 and on the last sample.
    tbl.push_back(mk(1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'(k), smp(8'h10, 3'(k)), k == 7));
    tbl.push_back(mk(1'b1, 8'h40, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, smp(8'h40, 3'd0), 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, smp(8'h40, 3'd1), 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, smp(8'h40, 3'd2), 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, smp(8'h40, 3'd2), 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, smp(8'h40, 3'd2), 1'b0));
    for (int k = 3; k < 7; k++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'(k), smp(8'h40, 3'(k)), 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd7, smp(8'h40, 3'd7), 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd7, smp(8'h40, 3'd7), 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));

    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      check($sformatf("tbl[%0d]", i), tbl[i].efr, tbl[i].eov, tbl[i].eidx, tbl[i].edat, tbl[i].elast);
      frame_valid = tbl[i].fv;
      set_frame(tbl[i].base);
      out_ready = tbl[i].ordy;
    end

    // Back-to-back frames A, B: 16 contiguous beats, ready low until A's last beat retires.
    @(negedge clk); frame_valid = 1'b1; set_frame(8'h00); out_ready = 1'b1;
    @(negedge clk); chk_beat("b2b_0", 1'b1, 8'h00, 3'd0); set_frame(8'h20);
    for (int j = 1; j < 16; j++) begin
      @(negedge clk);
      chk_beat($sformatf("b2b_%0d", j), j >= 8, (j < 8) ? 8'h00 : 8'h20, 3'(j % 8));
      frame_valid = 1'b0;
    end
    @(negedge clk); check("b2b_idle", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

    // Third frame offered while both banks are full is refused, then accepted after release.
    frame_valid = 1'b1; set_frame(8'h50); out_ready = 1'b0;
    @(negedge clk); chk_beat("full_a0", 1'b1, 8'h50, 3'd0); set_frame(8'h60);
    @(negedge clk); chk_beat("full_hold0", 1'b0, 8'h50, 3'd0); set_frame(8'h70);
    for (int r = 1; r <= 3; r++) begin
      @(negedge clk); chk_beat($sformatf("full_hold%0d", r), 1'b0, 8'h50, 3'd0);
    end
    frame_valid = 1'b0; out_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); chk_beat($sformatf("full_a%0d", k), 1'b0, 8'h50, 3'(k));
    end
    @(negedge clk); chk_beat("full_b0", 1'b1, 8'h60, 3'd0);
    frame_valid = 1'b1; set_frame(8'h70);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); chk_beat($sformatf("full_b%0d", k), 1'b0, 8'h60, 3'(k));
      frame_valid = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk_beat($sformatf("full_c%0d", k), 1'b1, 8'h70, 3'(k));
    end
    @(negedge clk); check("full_idle", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

    // Reset at sample 4 with a second frame buffered discards both.
    frame_valid = 1'b1; set_frame(8'h80); out_ready = 1'b1;
    @(negedge clk); chk_beat("rst_a0", 1'b1, 8'h80, 3'd0); set_frame(8'h90);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); chk_beat($sformatf("rst_a%0d", k), 1'b0, 8'h80, 3'(k));
      frame_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk); check("rst_after", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL rst_discard: got %0d valid cycles after reset, want 0", seen);
    end
    frame_valid = 1'b1; set_frame(8'hA0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk_beat($sformatf("post_rst%0d", k), 1'b1, 8'hA0, 3'(k));
      frame_valid = 1'b0;
    end
    @(negedge clk); check("post_rst_idle", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
